layer2_seq_ctrl: RTL and testbench
==================================

Name: layer2_seq_ctrl

Overview:
Sequencer for the layer-2 (hidden-to-output) stage of the MLP accelerator. On each start it walks hidden-neuron index 1..N_HID. For each index it drives the read enable and byte address of the 10-wide layer-2 weight SRAM and the hidden-activation buffer. It aligns MAC-enable strobes to the SRAM read latency and reports completion per image.
Sits between the top-level inference FSM and the layer-2 weight SRAM / 10-lane MAC array.

Parameters:
N_HID, 200, hidden neurons per image; must satisfy 1 <= N_HID <= 2^ADDR_W - 1.
RD_LAT, 2, clock cycles from address issue to weight data valid at SRAM outputs; must be >= 1.
ADDR_W, 8, width of the SRAM and activation address.
CNT_W, 16, width of the completed-image counter.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  request one layer-2 pass; sampled in IDLE and DONE only.
abort  in  1  synchronous cancel of an in-flight pass.
sram_re_en  out  1  weight SRAM read enable.
sram_addr  out  ADDR_W  weight SRAM byte address (1-based).
act_addr  out  ADDR_W  hidden-activation buffer address; always equal to sram_addr.
mac_clr  out  1  one-cycle clear of all 10 MAC accumulators.
mac_en  out  1  accumulate current weight×activation in all 10 lanes.
mac_last  out  1  marks the final mac_en of a pass.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse at pass completion.
img_cnt  out  CNT_W  completed passes since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, async): state=IDLE, k=0, latency pipe cleared, img_cnt=0. All outputs 0, including sram_addr and act_addr.
- Clock only clk. Every output is registered, with no combinational input-to-output paths.
- States: IDLE, CLEAR, ISSUE, DRAIN, DONE.
- IDLE: start=1 -> CLEAR. Otherwise stay.
- CLEAR (1 cycle): mac_clr=1, k loads 1 -> ISSUE.
- ISSUE (N_HID cycles): sram_re_en=1, sram_addr=act_addr=k, k increments each cycle. After issuing k=N_HID -> DRAIN.
- DRAIN (RD_LAT cycles): sram_re_en held 1 so SRAM outputs are not tri-stated. Address held at N_HID. Then -> DONE.
- DONE (1 cycle): done=1, img_cnt+1, sram_re_en=0. start=1 -> CLEAR (back-to-back). Otherwise -> IDLE.
- Latency pipe: RD_LAT-deep shift register fed with 1 in each ISSUE cycle and 0 otherwise.
  - mac_en = pipe output, so it is high for exactly N_HID consecutive cycles, beginning RD_LAT cycles after the first issue.
  - mac_last = mac_en on the cycle whose matching issue had k=N_HID. That cycle coincides with the last DRAIN cycle.
- Timing from start sampled in cycle 0:
  - CLEAR at cycle 1.
  - ISSUE at cycles 2..N_HID+1.
  - mac_en at cycles 2+RD_LAT..N_HID+1+RD_LAT.
  - done at cycle N_HID+RD_LAT+2; this is 204 for the defaults.
- start seen in CLEAR, ISSUE or DRAIN is ignored; it is not queued.
- abort=1 in CLEAR/ISSUE/DRAIN:
  - Next cycle state=IDLE, and sram_re_en, mac_en, mac_last and mac_clr drop to 0.
  - The pipe is flushed, k=0, and there is no done pulse or img_cnt change.
  - abort in IDLE or DONE has no effect. If abort and start are both high in DONE, abort is ignored and start wins.
- rst_n asserted mid-pass: immediate return to reset values, with no done pulse.
- k never exceeds N_HID. sram_addr is never 0 while sram_re_en=1.
- img_cnt wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Nominal, defaults: start pulse at cycle 0 -> mac_clr at cycle 1; sram_addr 1..200 on cycles 2..201; mac_en at cycles 4..203 (200 cycles), mac_last at cycle 203; done at cycle 204; img_cnt=1; busy low at cycle 205.
- Start while busy: start held high throughout a pass -> only one CLEAR per pass. Back-to-back passes: CLEAR follows each DONE directly, a new pass every 204 cycles, img_cnt increments once per done.
- Abort mid-ISSUE at sram_addr=50 -> next cycle state IDLE, sram_re_en=0, mac_en=0; no done pulse; img_cnt unchanged; a following start runs a full, correct pass.
- Async reset mid-DRAIN: rst_n low between clock edges -> all outputs 0 immediately, without waiting for a clock edge; img_cnt=0; no done pulse.
- Parameter corners: N_HID=1, RD_LAT=1 -> one address issued, mac_en and mac_last both high on cycle 3, done at cycle 4. Separately, CNT_W=2 with 5 passes -> img_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/layer2_seq_ctrl.sv
// Layer-2 sequencer: walks hidden index 1..N_HID, drives weight
// SRAM / activation reads and read-latency-aligned MAC strobes.
module layer2_seq_ctrl #(
    parameter int N_HID  = 200,
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              sram_re_en,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [ADDR_W-1:0] act_addr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              mac_last,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  img_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    localparam int DW = $clog2(RD_LAT + 1);
    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(N_HID);
    localparam logic [DW-1:0]     D_LAST = DW'(RD_LAT - 1);

    state_t              state;
    state_t              state_nx;
    logic [ADDR_W-1:0]   k;
    logic [DW-1:0]       dcnt;
    logic [RD_LAT-1:0]   pipe_en;
    logic [RD_LAT-1:0]   pipe_last;
    logic                in_pass;
    logic                kill;

    assign in_pass = (state == CLEAR) || (state == ISSUE) ||
                     (state == DRAIN);
    assign kill    = abort && in_pass;

    // Next-state decode; abort during a pass overrides everything.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = CLEAR;
            CLEAR:   state_nx = ISSUE;
            ISSUE:   if (k == K_LAST) state_nx = DRAIN;
            DRAIN:   if (dcnt == D_LAST) state_nx = DONE;
            DONE:    state_nx = start ? CLEAR : IDLE;
            default: state_nx = IDLE;
        endcase
        if (kill) state_nx = IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Address counter: 1..N_HID during ISSUE, held through DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= '0;
        end else if (kill) begin
            k <= '0;
        end else if (state == CLEAR) begin
            k <= ADDR_W'(1);
        end else if (state == ISSUE && k != K_LAST) begin
            k <= k + ADDR_W'(1);
        end else if (state == DRAIN && state_nx == DONE) begin
            k <= '0;
        end
    end

    // Drain cycle counter, cleared outside DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              dcnt <= '0;
        else if (state == DRAIN) dcnt <= dcnt + DW'(1);
        else                     dcnt <= '0;
    end

    // Read-latency pipes carrying MAC enable and last-element tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_en   <= '0;
            pipe_last <= '0;
        end else if (kill) begin
            pipe_en   <= '0;
            pipe_last <= '0;
        end else begin
            pipe_en[0]   <= (state == ISSUE);
            pipe_last[0] <= (state == ISSUE) && (k == K_LAST);
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_en[i]   <= pipe_en[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
        end
    end

    // Completed-image counter, bumped as the pass enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            img_cnt <= '0;
        else if (state == DRAIN && state_nx == DONE)
            img_cnt <= img_cnt + CNT_W'(1);
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign mac_clr    = (state == CLEAR);
    assign sram_re_en = (state == ISSUE) || (state == DRAIN);
    assign sram_addr  = k;
    assign act_addr   = k;
    assign mac_en     = pipe_en[RD_LAT-1];
    assign mac_last   = pipe_last[RD_LAT-1];

endmodule

// File: tb/tb_layer2_seq_ctrl.sv
// Directed bench for layer2_seq_ctrl: defaults, a minimal
// N_HID=1/RD_LAT=1 corner and a 2-bit image counter.
module tb_layer2_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start0, abort0, start1, start2;
    logic abort_z;

    logic       o0_re, o0_clr, o0_en, o0_last, o0_busy, o0_done;
    logic [7:0] o0_addr, o0_act;
    logic [15:0] o0_cnt;

    logic       o1_re, o1_clr, o1_en, o1_last, o1_busy, o1_done;
    logic [7:0] o1_addr, o1_act;
    logic [15:0] o1_cnt;

    logic       o2_re, o2_clr, o2_en, o2_last, o2_busy, o2_done;
    logic [7:0] o2_addr, o2_act;
    logic [1:0] o2_cnt;

    int total = 0;
    int bad   = 0;

    layer2_seq_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .sram_re_en(o0_re), .sram_addr(o0_addr), .act_addr(o0_act),
        .mac_clr(o0_clr), .mac_en(o0_en), .mac_last(o0_last),
        .busy(o0_busy), .done(o0_done), .img_cnt(o0_cnt)
    );

    layer2_seq_ctrl #(.N_HID(1), .RD_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort_z),
        .sram_re_en(o1_re), .sram_addr(o1_addr), .act_addr(o1_act),
        .mac_clr(o1_clr), .mac_en(o1_en), .mac_last(o1_last),
        .busy(o1_busy), .done(o1_done), .img_cnt(o1_cnt)
    );

    layer2_seq_ctrl #(.N_HID(3), .RD_LAT(2), .CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort_z),
        .sram_re_en(o2_re), .sram_addr(o2_addr), .act_addr(o2_act),
        .mac_clr(o2_clr), .mac_en(o2_en), .mac_last(o2_last),
        .busy(o2_busy), .done(o2_done), .img_cnt(o2_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(logic [31:0] cnt, logic [7:0] a,
                                       logic [7:0] aa, logic [5:0] fl);
        return {cnt, a, aa, 10'b0, fl};
    endfunction

    // Expected outputs c cycles after start was sampled (c=0: idle).
    function automatic bit ere(int c, int n, int r);
        return (c >= 2) && (c <= n + 1 + r);
    endfunction

    function automatic logic [63:0] ev(int c, int n, int r, int cnt);
        logic b, d, cl, re, en, la;
        int   a;
        cl = (c == 1);
        re = ere(c, n, r);
        en = (c >= 2 + r) && (c <= n + 1 + r);
        la = (c == n + 1 + r);
        b  = (c >= 1) && (c <= n + r + 2);
        d  = (c == n + r + 2);
        a  = !re ? 0 : ((c <= n + 1) ? c - 1 : n);
        return pk(32'(cnt), 8'(a), 8'(a), {b, d, cl, re, en, la});
    endfunction

    function automatic logic [63:0] ob0(bit m);
        return pk(32'(o0_cnt), m ? o0_addr : 8'h0, m ? o0_act : 8'h0,
                  {o0_busy, o0_done, o0_clr, o0_re, o0_en, o0_last});
    endfunction

    function automatic logic [63:0] ob1(bit m);
        return pk(32'(o1_cnt), m ? o1_addr : 8'h0, m ? o1_act : 8'h0,
                  {o1_busy, o1_done, o1_clr, o1_re, o1_en, o1_last});
    endfunction

    function automatic logic [63:0] ob2(bit m);
        return pk(32'(o2_cnt), m ? o2_addr : 8'h0, m ? o2_act : 8'h0,
                  {o2_busy, o2_done, o2_clr, o2_re, o2_en, o2_last});
    endfunction

    // One full default pass on u0 starting from IDLE.
    task automatic run_pass0(string tag, int base);
        start0 = 1'b1;
        for (int c = 1; c <= 206; c++) begin
            tick();
            if (c == 1) start0 = 1'b0;
            chk($sformatf("%s c=%0d", tag, c), ob0(ere(c, 200, 2)),
                ev(c, 200, 2, base + ((c >= 204) ? 1 : 0)));
        end
    endtask

    int done_seen;
    int cnt_tbl [5] = '{1, 2, 3, 0, 1};

    initial begin
        rst_n   = 1'b0;
        start0  = 1'b0;
        abort0  = 1'b0;
        start1  = 1'b0;
        start2  = 1'b0;
        abort_z = 1'b0;
        tick();
        tick();
        chk("reset u0", ob0(1'b1), 64'h0);
        chk("reset u1", ob1(1'b1), 64'h0);
        chk("reset u2", ob2(1'b1), 64'h0);
        rst_n = 1'b1;
        tick();

        // Nominal default pass alongside the N_HID=1/RD_LAT=1 corner.
        start0 = 1'b1;
        start1 = 1'b1;
        for (int c = 1; c <= 206; c++) begin
            tick();
            if (c == 1) begin
                start0 = 1'b0;
                start1 = 1'b0;
            end
            chk($sformatf("nom c=%0d", c), ob0(ere(c, 200, 2)),
                ev(c, 200, 2, (c >= 204) ? 1 : 0));
            if (c <= 6)
                chk($sformatf("n1r1 c=%0d", c), ob1(ere(c, 1, 1)),
                    ev(c, 1, 1, (c >= 4) ? 1 : 0));
            if (c == 3)
                chk("n1r1 en_last", 64'({o1_en, o1_last}), 64'b11);
        end

        // Start held high: one CLEAR per pass, back-to-back passes.
        start0 = 1'b1;
        for (int c = 1; c <= 409; c++) begin
            tick();
            if (c == 408) start0 = 1'b0;
            if (c <= 408) begin
                int r;
                r = ((c - 1) % 204) + 1;
                chk($sformatf("b2b c=%0d", c), ob0(ere(r, 200, 2)),
                    ev(r, 200, 2, 1 + c / 204));
            end else begin
                chk("b2b idle", ob0(1'b1), ev(0, 200, 2, 3));
            end
        end

        // Abort while issuing address 50.
        start0 = 1'b1;
        for (int c = 1; c <= 51; c++) begin
            tick();
            if (c == 1) start0 = 1'b0;
            chk($sformatf("abt c=%0d", c), ob0(ere(c, 200, 2)),
                ev(c, 200, 2, 3));
        end
        chk("abt addr50", 64'(o0_addr), 64'd50);
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
        chk("abt next", ob0(1'b1), ev(0, 200, 2, 3));
        done_seen = 0;
        for (int c = 0; c < 260; c++) begin
            tick();
            if (o0_done) done_seen++;
        end
        chk("abt no done", 64'(done_seen), 64'd0);
        chk("abt cnt", 64'(o0_cnt), 64'd3);
        run_pass0("post abt", 3);

        // Asynchronous reset during DRAIN.
        start0 = 1'b1;
        for (int c = 1; c <= 202; c++) begin
            tick();
            if (c == 1) start0 = 1'b0;
        end
        chk("drain pre", ob0(1'b1), ev(202, 200, 2, 4));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst", ob0(1'b1), 64'h0);
        tick();
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (o0_done) done_seen++;
        end
        chk("rst no done", 64'(done_seen), 64'd0);
        chk("rst idle", ob0(1'b1), 64'h0);

        // 2-bit image counter wraps over five back-to-back passes.
        start2 = 1'b1;
        for (int c = 1; c <= 35; c++) begin
            int r;
            tick();
            if (c == 35) start2 = 1'b0;
            r = ((c - 1) % 7) + 1;
            chk($sformatf("wrap c=%0d", c), ob2(ere(r, 3, 2)),
                ev(r, 3, 2, (c / 7) % 4));
            if (c % 7 == 0)
                chk($sformatf("wrap cnt p=%0d", c / 7),
                    64'({o2_done, o2_cnt}),
                    64'({1'b1, 2'(cnt_tbl[c / 7 - 1])}));
        end
        tick();
        chk("wrap idle", ob2(1'b1), ev(0, 3, 2, 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
